muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Parametrised iterative RV32M/RV64M-style multiply/divide unit that succeeds the EX-stage multiplier. Executes all eight M-extension operations (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) on XLEN-bit operands. Uses a valid/ready handshake on both request and response, plus a kill input for pipeline flushes. Sits in EX beside the ALU; busy drives the hazard unit's stall logic.

Parameters:
XLEN, 32, operand/result width; 32 or 64.
MUL_STEP, 1, multiplier bits retired per cycle; power of 2 in {1,2,4,8} dividing XLEN.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
in_valid  in  1  request present.
in_ready  out  1  unit can accept a request (state IDLE).
funct3  in  3  M-extension op; RISC-V funct3 encoding.
a  in  XLEN  rs1 operand.
b  in  XLEN  rs2 operand.
kill  in  1  synchronous abort of the in-flight op.
busy  out  1  op accepted and result not yet consumed.
out_valid  out  1  result valid.
out_ready  in  1  consumer takes the result.
result  out  XLEN  op result.

Behaviour:
- Reset (reset=0, async): state=IDLE; in_ready=1, busy=0, out_valid=0, result=0; internal regs cleared.
- Request acceptance: a request is accepted when in_valid & in_ready. funct3, a and b are latched on that edge.
- States: IDLE -> CALC -> FIX -> DONE -> IDLE.
- IDLE -> CALC on acceptance.
- CALC: multiply runs XLEN/MUL_STEP cycles as a shift-add on operand magnitudes. Divide runs XLEN cycles as a restoring divide, 1 quotient bit per cycle, on magnitudes.
- FIX (1 cycle): applies sign correction. Quotient is negated if signs differ. Remainder takes the dividend's sign. Product is negated per signedness (MULHSU: rs1 signed, rs2 unsigned). Selects the low or high XLEN bits of the 2*XLEN product.
- DONE: out_valid=1 and result stable until out_ready. Handshake returns to IDLE, with in_ready=1 on the next cycle.
- Latency (acceptance edge to first out_valid cycle): multiply = XLEN/MUL_STEP+2 cycles; divide = XLEN+2 cycles.
- Special cases bypass CALC/FIX (IDLE -> DONE, latency 1):
  - divide by zero: DIV/DIVU quotient = all ones; REM/REMU remainder = a.
  - signed overflow (a = -2^(XLEN-1), b = -1): DIV = a; REM = 0.
  - a multiply operand of 0 is not a special case.
- busy = (state != IDLE).
- kill: synchronous; highest priority. In any non-IDLE state, kill forces IDLE next cycle with out_valid=0 and result unchanged. A request presented in the same cycle as kill is not accepted. kill in IDLE has no effect.
- Result hold: out_valid stays 1 while out_ready=0, indefinitely. The result register changes only on the FIX -> DONE or IDLE -> DONE transition.
- Invalid config: XLEN not in {32,64}, or MUL_STEP not dividing XLEN, is an elaboration error.

Optional Feature:
MULDIV_REM_REUSE_EN:
- When defined: the unit keeps the quotient, remainder, operands and signedness of the last completed divide.
  - A DIV/REM pair (or DIVU/REMU pair) with the same a, b and signedness as that stored divide goes IDLE -> DONE with latency 1.
  - The stored divide is invalidated by reset, kill, or any completed divide with different operands.
- When undefined: no storage, and every divide takes full latency.

Decomposition:
- muldiv_pkg holds:
  - the funct3 enum (MUL=000, MULH=001, MULHSU=010, MULHU=011, DIV=100, DIVU=101, REM=110, REMU=111);
  - the state enum (IDLE/CALC/FIX/DONE);
  - helper functions is_div(funct3), is_signed_a(funct3), is_signed_b(funct3).
- One sub-module, div_step: a combinational single restoring iteration (partial remainder, divisor in; next remainder and quotient bit out), instantiated once in muldiv_unit.

Test Plan:
- MUL, a=7, b=0xFFFFFFFD (XLEN=32, MUL_STEP=1) -> result=0xFFFFFFEB, out_valid first at cycle 34 after acceptance.
- MULH, a=b=0x80000000 -> 0x40000000. MULHU, a=b=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU, a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
- DIV, a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF. Each completes in 34 cycles (1 cycle for the REM when MULDIV_REM_REUSE_EN is defined).
- DIVU, a=5, b=0 -> 0xFFFFFFFF; REMU -> 5; DIV, a=0x80000000, b=0xFFFFFFFF -> 0x80000000; REM -> 0. Each with latency 1.
- Start DIV, assert kill at cycle 10 -> out_valid never rises; in_ready=1 the next cycle; a new MUL 3*4 accepted then -> 12.
- Hold out_ready=0 for 5 cycles after DONE -> out_valid and result stable; in_valid ignored (in_ready=0). Pull reset low mid-CALC -> all outputs at reset values immediately.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op/state encodings and funct3 decode helpers shared by muldiv_unit.
package muldiv_pkg;
  typedef enum logic [2:0] {
    MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011,
    DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111
  } funct3_e;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;
  function automatic logic is_div(input logic [2:0] f);
    return f[2];
  endfunction
  function automatic logic is_signed_a(input logic [2:0] f);
    return f == MUL || f == MULH || f == MULHSU || f == DIV || f == REM;
  endfunction
  function automatic logic is_signed_b(input logic [2:0] f);
    return f == MUL || f == MULH || f == DIV || f == REM;
  endfunction
endpackage

// File: rtl/muldiv_unit_div_step.sv
// div_step: one restoring-division iteration yielding the next remainder and quotient bit.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   rem_i,
  input  logic [XLEN-1:0] dvs_i,
  output logic [XLEN-1:0] rem_o,
  output logic            q_o
);
  always_comb begin
    q_o = rem_i >= {1'b0, dvs_i};
    rem_o = q_o ? rem_i[XLEN-1:0] - dvs_i : rem_i[XLEN-1:0];
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M/RV64M multiply/divide with valid/ready handshake and kill.
// Define MULDIV_REM_REUSE_EN to answer a repeated DIV/REM pair from the last completed divide.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int MUL_STEP = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN + 1);
  if (!(XLEN == 32 || XLEN == 64) || !(MUL_STEP == 1 || MUL_STEP == 2 || MUL_STEP == 4 || MUL_STEP == 8)
      || XLEN % MUL_STEP != 0) begin : g_bad_cfg
    $error("muldiv_unit: unsupported XLEN/MUL_STEP combination");
  end
  state_e state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [2*XLEN-1:0] acc_q, acc_d, prod;
  logic [XLEN-1:0] opd_q, opd_d, res_q, res_d, a_mag, b_mag, quo, rem, dv_rem, hit_res;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [XLEN+MUL_STEP-1:0] sum;
  logic negp_q, negp_d, negr_q, negr_d, a_neg, b_neg, dz, ovf, accept, hit, dv_q;
  // acc holds {remainder, quotient} for divides and {product high, multiplier} for multiplies
  div_step #(.XLEN(XLEN)) u_div_step (
    .rem_i({acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]}),
    .dvs_i(opd_q),
    .rem_o(dv_rem),
    .q_o(dv_q)
  );
`ifdef MULDIV_REM_REUSE_EN
  logic [XLEN-1:0] ra_q, ra_d, rb_q, rb_d, rq_q, rq_d, rr_q, rr_d;
  logic rs_q, rs_d, rv_q, rv_d;
  assign hit = rv_q && ra_q == a && rb_q == b && rs_q == is_signed_a(funct3);
  assign hit_res = funct3[1] ? rr_q : rq_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ra_q <= '0;
      rb_q <= '0;
      rq_q <= '0;
      rr_q <= '0;
      rs_q <= 1'b0;
      rv_q <= 1'b0;
    end else begin
      ra_q <= ra_d;
      rb_q <= rb_d;
      rq_q <= rq_d;
      rr_q <= rr_d;
      rs_q <= rs_d;
      rv_q <= rv_d;
    end
  end
`else
  assign hit = 1'b0;
  assign hit_res = '0;
`endif
  always_comb begin
    a_neg = is_signed_a(funct3) & a[XLEN-1];
    b_neg = is_signed_b(funct3) & b[XLEN-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
    dz = is_div(funct3) && b == '0;
    ovf = is_div(funct3) && !funct3[0] && a == {1'b1, {(XLEN-1){1'b0}}} && b == '1;
    accept = in_valid && !kill && state_q == IDLE;
    sum = {{MUL_STEP{1'b0}}, acc_q[2*XLEN-1:XLEN]}
        + {{MUL_STEP{1'b0}}, opd_q} * {{XLEN{1'b0}}, acc_q[MUL_STEP-1:0]};
    prod = negp_q ? -acc_q : acc_q;
    quo = negp_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem = negr_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    state_d = state_q;
    op_d = op_q;
    acc_d = acc_q;
    opd_d = opd_q;
    cnt_d = cnt_q;
    negp_d = negp_q;
    negr_d = negr_q;
    res_d = res_q;
`ifdef MULDIV_REM_REUSE_EN
    ra_d = ra_q;
    rb_d = rb_q;
    rq_d = rq_q;
    rr_d = rr_q;
    rs_d = rs_q;
    rv_d = rv_q;
`endif
    if (kill && state_q != IDLE) state_d = IDLE;
    else if (accept) begin
      op_d = funct3;
      if (dz || ovf || (is_div(funct3) && hit)) begin
        state_d = DONE;
        res_d = dz ? (funct3[1] ? a : '1) : ovf ? (funct3[1] ? '0 : a) : hit_res;
`ifdef MULDIV_REM_REUSE_EN
        rv_d = hit;
`endif
      end else begin
        state_d = CALC;
        cnt_d = is_div(funct3) ? CW'(XLEN - 1) : CW'(XLEN / MUL_STEP - 1);
        acc_d = {{XLEN{1'b0}}, is_div(funct3) ? a_mag : b_mag};
        opd_d = is_div(funct3) ? b_mag : a_mag;
        negp_d = a_neg ^ b_neg;
        negr_d = a_neg;
`ifdef MULDIV_REM_REUSE_EN
        if (is_div(funct3)) begin
          ra_d = a;
          rb_d = b;
          rs_d = is_signed_a(funct3);
          rv_d = 1'b0;
        end
`endif
      end
    end else if (state_q == CALC) begin
      acc_d = is_div(op_q) ? {dv_rem, acc_q[XLEN-2:0], dv_q} : {sum, acc_q[XLEN-1:MUL_STEP]};
      cnt_d = cnt_q - CW'(1);
      state_d = cnt_q == '0 ? FIX : CALC;
    end else if (state_q == FIX) begin
      state_d = DONE;
      res_d = is_div(op_q) ? (op_q[1] ? rem : quo) : (op_q == MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
`ifdef MULDIV_REM_REUSE_EN
      if (is_div(op_q)) begin
        rq_d = quo;
        rr_d = rem;
        rv_d = 1'b1;
      end
`endif
    end else if (state_q == DONE && out_ready) state_d = IDLE;
`ifdef MULDIV_REM_REUSE_EN
    if (kill) rv_d = 1'b0;
`endif
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q <= '0;
      acc_q <= '0;
      opd_q <= '0;
      cnt_q <= '0;
      negp_q <= 1'b0;
      negr_q <= 1'b0;
      res_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      acc_q <= acc_d;
      opd_q <= opd_d;
      cnt_q <= cnt_d;
      negp_q <= negp_d;
      negr_q <= negr_d;
      res_q <= res_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign out_valid = state_q == DONE;
  assign result = res_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
  logic clk = 0, reset = 0, in_valid = 0, kill = 0, out_ready = 0;
  logic [2:0] funct3 = 0;
  logic [31:0] a = 0, b = 0;
  logic in_ready, busy, out_valid;
  logic [31:0] result;
  int checks = 0, errors = 0;
  bit rv = 0, rs = 0;
  logic [31:0] ra = 0, rb = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32), .MUL_STEP(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .funct3(funct3),
    .a(a), .b(b), .kill(kill), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .result(result)
  );

  function automatic bit is_ovf(input logic [2:0] f, input logic [31:0] x, y);
    return f[2] && !f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x, y);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    longint ux = longint'({32'b0, x});
    longint uy = longint'({32'b0, y});
    logic [63:0] p;
    int q;
    case (f)
      3'd0: begin p = sx * sy; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * uy; return p[63:32]; end
      3'd3: begin p = ux * uy; return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (is_ovf(f, x, y)) return x;
        q = $signed(x) / $signed(y);
        return q;
      end
      3'd5: return y == 0 ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (is_ovf(f, x, y)) return 32'h0;
        q = $signed(x) % $signed(y);
        return q;
      end
      default: return y == 0 ? x : x % y;
    endcase
  endfunction

  function automatic int lat(input logic [2:0] f, input logic [31:0] x, y);
    if (!f[2]) return 34;
    if (y == 0 || is_ovf(f, x, y)) return 1;
`ifdef MULDIV_REM_REUSE_EN
    if (rv && ra == x && rb == y && rs == !f[0]) return 1;
`endif
    return 34;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic run_op(input logic [2:0] f, input logic [31:0] x, y, exp_r, input int hold);
    int c = 0;
    int exp_l = lat(f, x, y);
    logic [31:0] held;
    @(negedge clk);
    in_valid = 1; funct3 = f; a = x; b = y;
    @(posedge clk); #1;
    in_valid = 0; a = $urandom; b = $urandom; funct3 = 3'($urandom);
    do begin @(negedge clk); c++; end while (!out_valid && c < 200);
    checks++;
    if (c !== exp_l) begin
      errors++;
      $display("FAIL latency f=%0d a=%h b=%h: got %0d cycles, expected %0d", f, x, y, c, exp_l);
    end
    checks++;
    if (result !== exp_r) begin
      errors++;
      $display("FAIL result f=%0d a=%h b=%h: got %h, expected %h", f, x, y, result, exp_r);
    end
    held = result;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1; a = $urandom; b = $urandom;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || result !== held || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold cycle %0d: out_valid=%b result=%h in_ready=%b, expected 1/%h/0", i, out_valid, result, in_ready, held);
      end
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL handshake: in_ready=%b out_valid=%b, expected 1/0", in_ready, out_valid);
    end
    if (f[2]) begin
      if (y == 0 || is_ovf(f, x, y)) rv = 0;
      else if (exp_l == 34) begin rv = 1; ra = x; rb = y; rs = !f[0]; end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, busy, out_valid} !== 3'b100 || result !== 32'h0) begin
      errors++;
      $display("FAIL reset: rdy/busy/vld=%b%b%b result=%h, expected 100/0", in_ready, busy, out_valid, result);
    end
    reset = 1;
  endtask

  task automatic test_directed;
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 5);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
    run_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
    run_op(3'd7, 32'd5, 32'd0, 32'd5, 0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 3);
  endtask

  task automatic test_random_mul;
    for (int i = 0; i < 16; i++) begin
      logic [2:0] f = 3'($urandom_range(0, 3));
      logic [31:0] x = pick(), y = pick();
      run_op(f, x, y, model(f, x, y), 0);
    end
  endtask

  task automatic test_random_div;
    for (int i = 0; i < 16; i++) begin
      logic [2:0] f = 3'($urandom_range(4, 7));
      logic [31:0] x = pick(), y = pick();
      if ($urandom_range(0, 5) == 0) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
      run_op(f, x, y, model(f, x, y), 0);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++) begin
      logic [2:0] f = (i % 2 == 0) ? 3'd4 : 3'd5;
      logic [31:0] x = $urandom, y = 32'($urandom_range(1, 1000));
      run_op(f, x, y, model(f, x, y), 0);
      run_op(f | 3'd2, x, y, model(f | 3'd2, x, y), 0);
    end
  endtask

  task automatic test_kill;
    int seen = 0;
    logic [31:0] prev = result;
    @(negedge clk);
    in_valid = 1; funct3 = 3'd4; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    in_valid = 0;
    for (int i = 1; i < 10; i++) begin @(negedge clk); if (out_valid) seen++; end
    @(negedge clk);
    kill = 1; in_valid = 1; funct3 = 3'd0; a = 32'd9; b = 32'd9;
    @(posedge clk); #1;
    kill = 0; in_valid = 0; rv = 0;
    @(negedge clk);
    checks++;
    if (seen !== 0 || out_valid !== 1'b0 || in_ready !== 1'b1 || result !== prev) begin
      errors++;
      $display("FAIL kill: seen=%0d out_valid=%b in_ready=%b result=%h, expected 0/0/1/%h", seen, out_valid, in_ready, result, prev);
    end
    kill = 1; in_valid = 1;
    @(posedge clk); #1;
    kill = 0; in_valid = 0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL kill_blocks_accept: busy=%b in_ready=%b, expected 0/1", busy, in_ready);
    end
    run_op(3'd0, 32'd3, 32'd4, 32'd12, 0);
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    in_valid = 1; funct3 = 3'd1; a = $urandom; b = $urandom;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (5) @(negedge clk);
    #2 reset = 0;
    #1;
    checks++;
    if ({in_ready, busy, out_valid} !== 3'b100 || result !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: rdy/busy/vld=%b%b%b result=%h, expected 100/0", in_ready, busy, out_valid, result);
    end
    @(negedge clk);
    reset = 1; rv = 0;
    run_op(3'd7, 32'd100, 32'd7, 32'd2, 0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random_mul();
    test_random_div();
    test_back_to_back();
    test_kill();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
